// File: rtl/gpr_file_mp.sv
// Multi-port register file with write->read bypass, r0 hardwired to zero.
// Optional pending-write scoreboard enabled by defining GPR_SCOREBOARD_EN.
module gpr_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_WR-1:0]        wclr,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [ADDR_W:0]          sb_cnt,
  output logic                     sb_err
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wport
      assign wa[gi] = waddr[gi*ADDR_W +: ADDR_W];
      assign wd[gi] = wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Ascending port loop: the last nonblocking assignment (highest index) wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i] && wa[i] != '0) regs[wa[i]] <= wd[i];
      end
    end
  end

`ifdef GPR_SCOREBOARD_EN
  logic [NREG-1:0] busy_reg, busy_next, clr_mask, set_mask;
  logic [ADDR_W:0] cnt_reg, cnt_next;
  logic            err_reg, err_hit;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i] && wclr[i]) clr_mask[wa[i]] = 1'b1;
    end
    clr_mask[0] = 1'b0;
    set_mask = '0;
    if (sb_set) set_mask[sb_addr] = 1'b1;
    set_mask[0] = 1'b0;
    // Set is applied after clear so a same-cycle set keeps the register busy.
    busy_next = (busy_reg & ~clr_mask) | set_mask;
    err_hit   = sb_set && (sb_addr != '0) && busy_reg[sb_addr] && !clr_mask[sb_addr];
    cnt_next  = '0;
    for (int r = 0; r < NREG; r++) cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[r]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
      if (err_hit) err_reg <= 1'b1;
    end
  end

  assign sb_cnt = cnt_reg;
  assign sb_err = err_reg;
`else
  logic sb_unused;
  assign sb_unused = ^{sb_set, sb_addr, wclr};
  assign sb_cnt    = '0;
  assign sb_err    = 1'b0;
`endif

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rport
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] val;
      assign ra = raddr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        val = regs[ra];
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] && wa[i] == ra) val = wd[i];
        end
        if (!re[gi] || ra == '0) val = '0;
      end
      assign rdata[gi*DATA_W +: DATA_W] = val;

`ifdef GPR_SCOREBOARD_EN
      assign rbusy[gi] = re[gi] && (ra != '0) && busy_reg[ra] && !clr_mask[ra];
`else
      assign rbusy[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_gpr_file_mp.sv
// Scoreboard bench for gpr_file_mp: stimulus queues expectations, a negedge monitor checks them.
// Expectations adapt to GPR_SCOREBOARD_EN.
module tb_gpr_file_mp;
  localparam int DW = 32, AW = 5, NR = 4, NW = 2;
`ifdef GPR_SCOREBOARD_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NW-1:0]      we, wclr;
  logic [NW*AW-1:0]   waddr;
  logic [NW*DW-1:0]   wdata;
  logic [NR-1:0]      re;
  logic [NR*AW-1:0]   raddr;
  logic [NR*DW-1:0]   rdata;
  logic [NR-1:0]      rbusy;
  logic               sb_set;
  logic [AW-1:0]      sb_addr;
  logic [AW:0]        sb_cnt;
  logic               sb_err;

  gpr_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wclr(wclr),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_cnt(sb_cnt), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 rdata, 1 rbusy, 2 sb_cnt, 3 sb_err
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic chk_valid = 1'b0;

  always @(negedge clk) begin
    if (chk_valid) begin
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        case (e.kind)
          0:       act = rdata[e.idx*DW +: DW];
          1:       act = {31'b0, rbusy[e.idx]};
          2:       act = {26'b0, sb_cnt};
          default: act = {31'b0, sb_err};
        endcase
        tests++;
        if (act !== e.val) begin
          fails++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
        end else begin
          $display("ok   %s = 0x%08h", e.name, act);
        end
      end
    end
  end

  task automatic idle();
    we = '0; wclr = '0; waddr = '0; wdata = '0;
    re = '0; raddr = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d, input bit c);
    we[p] = 1'b1; wclr[p] = c;
    waddr[p*AW +: AW] = a[AW-1:0];
    wdata[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    re[p] = 1'b1;
    raddr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic ex(input int k, input int i, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k; e.idx = i; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  // Present the current vector for one cycle, then clear inputs.
  task automatic step();
    chk_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd(0, 3); ex(0, 0, 32'h0, "reset_rd_r3");
    ex(2, 0, 32'h0, "reset_sb_cnt");
    ex(3, 0, 32'h0, "reset_sb_err");
    step();
    rst_n = 1'b1;

    // Write then read, same-cycle bypass
    wr(0, 5, 32'h1234_5678, 1'b0); rd(0, 5); rd(1, 6);
    ex(0, 0, 32'h1234_5678, "bypass_r5");
    ex(0, 1, 32'h0, "unwritten_r6");
    step();
    rd(0, 5); ex(0, 0, 32'h1234_5678, "stored_r5");
    step();

    // Write conflict: port 1 wins
    wr(0, 7, 32'hA, 1'b0); wr(1, 7, 32'hB, 1'b0); rd(1, 7);
    ex(0, 1, 32'hB, "conflict_bypass_r7");
    step();
    // r0 write dropped, read-enable gating
    wr(0, 0, 32'hFFFF_FFFF, 1'b0); rd(0, 0); rd(3, 7);
    raddr[2*AW +: AW] = 5'd7;
    ex(0, 0, 32'h0, "r0_bypass_zero");
    ex(0, 2, 32'h0, "re_gated_r7");
    ex(0, 3, 32'hB, "stored_r7");
    step();
    rd(0, 0); rd(1, 7); ex(0, 0, 32'h0, "r0_stored_zero"); ex(0, 1, 32'hB, "r7_after");
    step();

    // Scoreboard set / wait / clearing write
    sb_set = 1'b1; sb_addr = 5'd9; rd(0, 9);
    ex(1, 0, 32'h0, "sb_set_cycle_rbusy");
    ex(2, 0, 32'h0, "sb_set_cycle_cnt");
    step();
    for (int c = 0; c < 3; c++) begin
      rd(0, 9);
      ex(1, 0, {31'b0, EN}, "pending_rbusy_r9");
      ex(2, 0, EN ? 32'd1 : 32'd0, "pending_cnt");
      step();
    end
    wr(1, 9, 32'h55, 1'b1); rd(0, 9); rd(2, 9);
    ex(1, 0, 32'h0, "clr_cycle_rbusy");
    ex(0, 2, 32'h55, "clr_cycle_rdata");
    ex(2, 0, EN ? 32'd1 : 32'd0, "clr_cycle_cnt");
    step();
    rd(0, 9); ex(2, 0, 32'h0, "after_clr_cnt"); ex(1, 0, 32'h0, "after_clr_rbusy");
    ex(0, 0, 32'h55, "after_clr_rdata");
    step();

    // Double set -> sticky error
    sb_set = 1'b1; sb_addr = 5'd9;
    step();
    sb_set = 1'b1; sb_addr = 5'd9;
    ex(3, 0, 32'h0, "err_before_edge");
    step();
    ex(3, 0, {31'b0, EN}, "double_set_err");
    ex(2, 0, EN ? 32'd1 : 32'd0, "double_set_cnt");
    step();

    // Set and clearing write to r4 in one cycle: set wins
    sb_set = 1'b1; sb_addr = 5'd4; wr(0, 4, 32'h44, 1'b1); rd(1, 4);
    ex(1, 1, 32'h0, "setclr_rbusy_r4");
    ex(0, 1, 32'h44, "setclr_rdata_r4");
    step();
    rd(1, 4);
    ex(1, 1, {31'b0, EN}, "r4_stays_busy");
    ex(2, 0, EN ? 32'd2 : 32'd0, "cnt_two");
    ex(3, 0, {31'b0, EN}, "err_sticky");
    step();
    // Clear of a non-busy register has no effect
    wr(1, 5, 32'h77, 1'b1);
    step();
    ex(2, 0, EN ? 32'd2 : 32'd0, "clr_nonbusy_cnt");
    step();

    // Mid-run asynchronous reset
    rst_n = 1'b0;
    rd(0, 5); rd(1, 7); rd(2, 9); rd(3, 4);
    ex(0, 0, 32'h0, "rst_r5"); ex(0, 1, 32'h0, "rst_r7");
    ex(0, 2, 32'h0, "rst_r9"); ex(0, 3, 32'h0, "rst_r4");
    ex(1, 3, 32'h0, "rst_rbusy_r4");
    ex(2, 0, 32'h0, "rst_cnt"); ex(3, 0, 32'h0, "rst_err");
    step();
    rst_n = 1'b1;
    rd(0, 5); rd(3, 4);
    ex(0, 0, 32'h0, "post_rst_r5"); ex(0, 3, 32'h0, "post_rst_r4");
    ex(2, 0, 32'h0, "post_rst_cnt"); ex(3, 0, 32'h0, "post_rst_err");
    step();

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d entries, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
